// File: rtl/seg7_scan_display_if.sv
// Data-memory write bus as seen by the LED snooper: address, write enable and write data.
// The CPU side drives it; the display side only listens.
interface seg7_scan_display_if;
   logic [31:0] addr;
   logic        wen;
   logic [31:0] datain;

   modport master (output addr, output wen, output datain);
   modport slave  (input addr, input wen, input datain);
endinterface

// File: rtl/seg7_scan_display.sv
// Snoops writes to the LED register and scans the shadowed 32-bit value as eight hex
// digits onto a common-anode 7-segment board, with dead time and optional zero blanking.
module seg7_scan_display #(
   parameter int unsigned SCAN_DIV    = 50000,
   parameter int unsigned DEAD_CYCLES = 1000,
   parameter logic [31:0] DATA_ADDR   = 32'hFFFF_F000,
   parameter logic [31:0] CTRL_ADDR   = 32'hFFFF_F004
) (
   input  logic               clk_i,
   input  logic               rst_i,
   seg7_scan_display_if.slave bus,
   output logic [7:0]         led_en,
   output logic [6:0]         led_seg,
   output logic               led_dp
);

   localparam int unsigned    CntW    = $clog2(SCAN_DIV);
   localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
   // DEAD_CYCLES < SCAN_DIV <= 2**CntW, so it always fits in CntW bits.
   localparam logic [CntW:0]  DeadLim = {1'b0, CntW'(DEAD_CYCLES)};

   logic [31:0]     shadow_q, shadow_d;
   logic            lzb_q, lzb_d;
   logic [CntW-1:0] pcnt_q, pcnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      led_en_q, led_en_d;
   logic [6:0]      led_seg_q, led_seg_d;

   logic [2:0]      hi_nz;
   logic [3:0]      nibble;
   logic            dark;
   logic            suppress;

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      logic [6:0] g;
      unique case (n)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         4'hF: g = 7'h0E;
      endcase
      return g;
   endfunction

   always_comb begin
      shadow_d = shadow_q;
      lzb_d    = lzb_q;
      if (bus.wen && (bus.addr == DATA_ADDR)) begin
         shadow_d = bus.datain;
      end
      if (bus.wen && (bus.addr == CTRL_ADDR)) begin
         lzb_d = bus.datain[0];
      end
   end

   always_comb begin
      pcnt_d = pcnt_q + CntW'(1);
      idx_d  = idx_q;
      if (pcnt_q == CntMax) begin
         pcnt_d = '0;
         idx_d  = idx_q + 3'd1;
      end
   end

   // Index of the highest nonzero nibble; an all-zero value reports digit 0.
   always_comb begin
      hi_nz = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (shadow_q[4*i +: 4] != 4'h0) begin
            hi_nz = 3'(i);
         end
      end
   end

   assign nibble   = shadow_q[{idx_q, 2'b00} +: 4];
   // pcnt < DEAD_CYCLES, written so a zero dead time does not compare against a constant 0.
   assign dark     = (({1'b0, pcnt_q} + (CntW + 1)'(1)) <= DeadLim);
   assign suppress = lzb_q && (idx_q > hi_nz);

   always_comb begin
      led_en_d  = 8'hFF;
      led_seg_d = 7'h7F;
      if (!dark && !suppress) begin
         led_en_d  = ~(8'h01 << idx_q);
         led_seg_d = hex_glyph(nibble);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q  <= '0;
         lzb_q     <= 1'b0;
         pcnt_q    <= '0;
         idx_q     <= 3'd0;
         led_en_q  <= 8'hFF;
         led_seg_q <= 7'h7F;
      end else begin
         shadow_q  <= shadow_d;
         lzb_q     <= lzb_d;
         pcnt_q    <= pcnt_d;
         idx_q     <= idx_d;
         led_en_q  <= led_en_d;
         led_seg_q <= led_seg_d;
      end
   end

   assign led_en  = led_en_q;
   assign led_seg = led_seg_q;
   assign led_dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: each clock pushes the expected pins, the
// observed pins are queued alongside, and every scenario drains and compares both.
module tb_seg7_scan_display;

   localparam int unsigned SD     = 8;
   localparam int unsigned DC     = 2;
   localparam logic [31:0] DATA_A = 32'hFFFF_F000;
   localparam logic [31:0] CTRL_A = 32'hFFFF_F004;

   logic       clk = 1'b0;
   logic       rst_i = 1'b0;
   logic [7:0] led_en;
   logic [6:0] led_seg;
   logic       led_dp;

   seg7_scan_display_if bus();

   seg7_scan_display #(
      .SCAN_DIV   (SD),
      .DEAD_CYCLES(DC),
      .DATA_ADDR  (DATA_A),
      .CTRL_ADDR  (CTRL_A)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst_i),
      .bus    (bus),
      .led_en (led_en),
      .led_seg(led_seg),
      .led_dp (led_dp)
   );

   always #5 clk = ~clk;

   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic [31:0] m_shadow = '0;
   logic        m_lzb = 1'b0;
   int          k = 0;
   logic [14:0] exp_q [$];
   logic [14:0] obs_q [$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          multi_low = 0;
   int          lit_cnt [8];
   logic [6:0]  lit_seg [8];

   // Pins expected after the k-th edge since reset release, using the pre-edge state.
   function automatic logic [14:0] exp_pins(input int kk);
      int         p;
      int         ix;
      int         h;
      logic [7:0] en;
      p  = (kk - 1) % SD;
      ix = ((kk - 1) / SD) % 8;
      h  = 0;
      for (int i = 0; i < 8; i++) begin
         if (m_shadow[4*i +: 4] != 4'h0) h = i;
      end
      if (p < DC || (m_lzb && ix > h)) return {8'hFF, 7'h7F};
      en = ~(8'h01 << ix);
      return {en, glyph[m_shadow[4*ix +: 4]]};
   endfunction

   task automatic tick();
      logic [14:0] e;
      if (rst_i) begin
         e = {8'hFF, 7'h7F};
      end else begin
         k++;
         e = exp_pins(k);
      end
      exp_q.push_back(e);
      if (rst_i) begin
         m_shadow = '0;
         m_lzb    = 1'b0;
         k        = 0;
      end else if (bus.wen) begin
         if (bus.addr == DATA_A) m_shadow = bus.datain;
         else if (bus.addr == CTRL_A) m_lzb = bus.datain[0];
      end
      @(posedge clk);
      #1;
      obs_q.push_back({led_en, led_seg});
      if ($countones(~led_en) > 1) multi_low++;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      bus.addr   = a;
      bus.datain = d;
      bus.wen    = 1'b1;
      tick();
      bus.wen    = 1'b0;
   endtask

   task automatic do_reset();
      bus.wen = 1'b0;
      rst_i   = 1'b1;
      tick();
      rst_i   = 1'b0;
   endtask

   // Runs n cycles and records, per digit, how many cycles it was lit and its last glyph.
   task automatic scan_record(input int n);
      for (int i = 0; i < 8; i++) begin
         lit_cnt[i] = 0;
         lit_seg[i] = 7'h7F;
      end
      for (int c = 0; c < n; c++) begin
         tick();
         for (int i = 0; i < 8; i++) begin
            if (!led_en[i]) begin
               lit_cnt[i]++;
               lit_seg[i] = led_seg;
            end
         end
      end
   endtask

   task automatic test_reset();
      logic [14:0] e, o;
      do_reset();
      n_tests++;
      if ({led_en, led_seg, led_dp} !== {8'hFF, 7'h7F, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_pins: got en=%h seg=%h dp=%b, want FF/7F/1", led_en, led_seg, led_dp);
      end
      tick();
      tick();
      tick();
      n_tests++;
      if ({led_en, led_seg} !== {8'hFE, 7'h40}) begin
         n_fail++;
         $display("FAIL reset_first_digit: got en=%h seg=%h, want FE/40", led_en, led_seg);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_sb: got %h/%h want %h/%h", o[14:7], o[6:0], e[14:7], e[6:0]);
         end
      end
   endtask

   task automatic test_full_scan();
      logic [14:0] e, o;
      logic [6:0]  want [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
      do_reset();
      bus_wr(DATA_A, 32'h89AB_CDEF);
      scan_record(8 * SD);
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (lit_cnt[i] != int'(SD - DC) || lit_seg[i] !== want[i]) begin
            n_fail++;
            $display("FAIL scan_digit%0d: got %0d cycles seg=%h, want %0d cycles seg=%h",
                     i, lit_cnt[i], lit_seg[i], SD - DC, want[i]);
         end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL scan_sb: got %h/%h want %h/%h", o[14:7], o[6:0], e[14:7], e[6:0]);
         end
      end
   endtask

   task automatic test_lzb();
      logic [14:0] e, o;
      int          want_cnt [8] = '{6, 6, 6, 0, 0, 0, 0, 0};
      logic [6:0]  want_seg [3] = '{7'h40, 7'h24, 7'h79};
      do_reset();
      bus_wr(CTRL_A, 32'h1);
      bus_wr(DATA_A, 32'h0000_0120);
      scan_record(8 * SD);
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (lit_cnt[i] != want_cnt[i] || (i < 3 && lit_seg[i] !== want_seg[i])) begin
            n_fail++;
            $display("FAIL lzb_digit%0d: got %0d cycles seg=%h, want %0d cycles",
                     i, lit_cnt[i], lit_seg[i], want_cnt[i]);
         end
      end
      bus_wr(DATA_A, 32'h0);
      scan_record(8 * SD);
      n_tests++;
      if (lit_cnt[0] != 6 || lit_seg[0] !== 7'h40 ||
          (lit_cnt[1] + lit_cnt[2] + lit_cnt[3] + lit_cnt[4] +
           lit_cnt[5] + lit_cnt[6] + lit_cnt[7]) != 0) begin
         n_fail++;
         $display("FAIL lzb_zero: got d0 %0d cycles seg=%h d1 %0d cycles, want only d0 6 cycles seg=40",
                  lit_cnt[0], lit_seg[0], lit_cnt[1]);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL lzb_sb: got %h/%h want %h/%h", o[14:7], o[6:0], e[14:7], e[6:0]);
         end
      end
   endtask

   task automatic test_decode();
      logic [14:0] e, o;
      logic [6:0]  want [8] = '{7'h12, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
      do_reset();
      bus_wr(DATA_A, 32'h0000_00A5);
      bus_wr(32'hFFFF_F070, 32'hFFFF_FFFF);
      bus_wr(32'h0000_4000, 32'hFFFF_FFFF);
      bus_wr(32'hFFFF_F008, 32'hFFFF_FFFF);
      bus.addr   = DATA_A;
      bus.datain = 32'hFFFF_FFFF;
      bus.wen    = 1'b0;
      tick();
      scan_record(8 * SD);
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (lit_cnt[i] != 6 || lit_seg[i] !== want[i]) begin
            n_fail++;
            $display("FAIL decode_digit%0d: got %0d cycles seg=%h, want 6 cycles seg=%h",
                     i, lit_cnt[i], lit_seg[i], want[i]);
         end
      end
      bus_wr(CTRL_A, 32'h1);
      bus_wr(32'hFFFF_F008, 32'h0);
      bus_wr(32'hFFFF_F070, 32'h0);
      bus.addr = CTRL_A;
      bus.datain = 32'h0;
      tick();
      scan_record(8 * SD);
      n_tests++;
      if (lit_cnt[0] != 6 || lit_cnt[1] != 6 || lit_cnt[2] != 0 || lit_cnt[7] != 0) begin
         n_fail++;
         $display("FAIL decode_lzb_kept: got cycles d0=%0d d1=%0d d2=%0d d7=%0d, want 6/6/0/0",
                  lit_cnt[0], lit_cnt[1], lit_cnt[2], lit_cnt[7]);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL decode_sb: got %h/%h want %h/%h", o[14:7], o[6:0], e[14:7], e[6:0]);
         end
      end
   endtask

   task automatic test_write_latency();
      logic [14:0] e, o;
      do_reset();
      tick();
      tick();
      tick();
      bus_wr(DATA_A, 32'h0000_0007);
      n_tests++;
      if (led_seg !== 7'h40) begin
         n_fail++;
         $display("FAIL latency_write_edge: got seg=%h, want 40", led_seg);
      end
      tick();
      n_tests++;
      if ({led_en, led_seg} !== {8'hFE, 7'h78}) begin
         n_fail++;
         $display("FAIL latency_next_edge: got en=%h seg=%h, want FE/78", led_en, led_seg);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL latency_sb: got %h/%h want %h/%h", o[14:7], o[6:0], e[14:7], e[6:0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [14:0] e, o;
      do_reset();
      bus_wr(DATA_A, 32'h8765_4321);
      while (k < 44) tick();
      n_tests++;
      if ({led_en, led_seg} !== {8'hDF, 7'h02}) begin
         n_fail++;
         $display("FAIL mid_digit5: got en=%h seg=%h, want DF/02", led_en, led_seg);
      end
      rst_i      = 1'b1;
      bus.addr   = DATA_A;
      bus.datain = 32'hFFFF_FFFF;
      bus.wen    = 1'b1;
      tick();
      bus.wen = 1'b0;
      rst_i   = 1'b0;
      n_tests++;
      if ({led_en, led_seg} !== {8'hFF, 7'h7F}) begin
         n_fail++;
         $display("FAIL mid_reset_pins: got en=%h seg=%h, want FF/7F", led_en, led_seg);
      end
      tick();
      tick();
      tick();
      n_tests++;
      if ({led_en, led_seg} !== {8'hFE, 7'h40}) begin
         n_fail++;
         $display("FAIL mid_write_dropped: got en=%h seg=%h, want FE/40", led_en, led_seg);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL mid_sb: got %h/%h want %h/%h", o[14:7], o[6:0], e[14:7], e[6:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [14:0] e, o;
      do_reset();
      for (int c = 0; c < 300; c++) begin
         case ($urandom_range(0, 3))
            0:       bus.addr = DATA_A;
            1:       bus.addr = CTRL_A;
            2:       bus.addr = 32'hFFFF_F008;
            default: bus.addr = $urandom;
         endcase
         bus.datain = $urandom >> $urandom_range(0, 31);
         bus.wen    = 1'($urandom_range(0, 1));
         tick();
      end
      bus.wen = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL b2b_sb: got %h/%h want %h/%h", o[14:7], o[6:0], e[14:7], e[6:0]);
         end
      end
      n_tests++;
      if (multi_low != 0) begin
         n_fail++;
         $display("FAIL one_hot_enable: got %0d cycles with >1 enable low, want 0", multi_low);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t, want finished", $time);
      $fatal(1, "timeout");
   end

   initial begin
      bus.addr   = '0;
      bus.datain = '0;
      bus.wen    = 1'b0;
      test_reset();
      test_full_scan();
      test_lzb();
      test_decode();
      test_write_latency();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
